// File: rtl/bit_deserializer.sv
// -----------------------------------------------------------------------------
// bit_deserializer
//
// Serial-to-parallel converter for the ZigBee baseband receive path. It
// collects one bit per valid input cycle, LSB first, into a WIDTH-bit word.
// Each completed word is offered on a valid/ready output handshake. When the
// output register is still occupied and the downstream is stalled, the new
// word is dropped and outOverflow pulses for one cycle.
//
// Parameters:
//   WIDTH        bits per output word, legal range 2..32
//                (8 = byte reassembly, 4 = ZigBee symbol)
//
// Ports:
//   inClk        system clock, rising edge
//   inResetN     asynchronous active-low reset
//   inBit        serial data bit
//   inValid      inBit is valid this cycle (always accepted)
//   inClear      synchronous flush of the partial word and the output register
//   outReady     downstream accepts outData this cycle
//   outData      assembled word, first-received bit at bit 0
//   outValid     outData holds an unconsumed word
//   outBusy      a partial word is in progress
//   outOverflow  one-cycle pulse when a completed word is discarded
//   outOvfCount  saturating count of overflow pulses
//                (present only with DESER_OVERFLOW_CNT_EN)
//
// Build option:
//   DESER_OVERFLOW_CNT_EN  adds the outOvfCount port and its counter.
// -----------------------------------------------------------------------------
module bit_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             inClk,
   input  logic             inResetN,
   input  logic             inBit,
   input  logic             inValid,
   input  logic             inClear,
   input  logic             outReady,
   output logic [WIDTH-1:0] outData,
   output logic             outValid,
   output logic             outBusy,
   output logic             outOverflow
`ifdef DESER_OVERFLOW_CNT_EN
   ,
   output logic [7:0]       outOvfCount
`endif
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    bitCnt;
   logic [CW-1:0]    cntNext;
   logic [WIDTH-1:0] shiftReg;
   logic [WIDTH-1:0] shiftNext;
   logic [WIDTH-1:0] dataNext;
   logic             validNext;
   logic             ovfNext;
   logic             busyNext;

   // NOTE: every variable gets a default at the top of the block so that no
   // path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      cntNext   = bitCnt;
      shiftNext = shiftReg;
      dataNext  = outData;
      validNext = outValid;
      ovfNext   = 1'b0;

      // A transfer empties the output register unless a new word refills it.
      if (outValid && outReady) begin
         validNext = 1'b0;
      end

      if (inValid) begin
         shiftNext[bitCnt] = inBit;
         if (bitCnt == LAST) begin
            cntNext = '0;
            // shiftNext now holds the complete word including the current bit.
            if (!outValid || outReady) begin
               dataNext  = shiftNext;
               validNext = 1'b1;
            end else begin
               ovfNext = 1'b1;
            end
         end else begin
            cntNext = bitCnt + CW'(1);
         end
      end

      // Clear overrides everything above; outData is don't-care once invalid.
      if (inClear) begin
         cntNext   = '0;
         shiftNext = '0;
         dataNext  = outData;
         validNext = 1'b0;
         ovfNext   = 1'b0;
      end

      busyNext = (cntNext != '0);
   end

   // NOTE: state registers use non-blocking assignments so all of them update
   // together from values computed in the previous cycle.
   always_ff @(posedge inClk or negedge inResetN) begin
      if (!inResetN) begin
         bitCnt      <= '0;
         shiftReg    <= '0;
         outData     <= '0;
         outValid    <= 1'b0;
         outBusy     <= 1'b0;
         outOverflow <= 1'b0;
      end else begin
         bitCnt      <= cntNext;
         shiftReg    <= shiftNext;
         outData     <= dataNext;
         outValid    <= validNext;
         outBusy     <= busyNext;
         outOverflow <= ovfNext;
      end
   end

`ifdef DESER_OVERFLOW_CNT_EN
   // Counts the registered overflow pulses, so it trails outOverflow by one
   // cycle; saturates rather than wrapping so a long stall stays visible.
   always_ff @(posedge inClk or negedge inResetN) begin
      if (!inResetN) begin
         outOvfCount <= '0;
      end else if (inClear) begin
         outOvfCount <= '0;
      end else if (outOverflow && (outOvfCount != 8'hFF)) begin
         outOvfCount <= outOvfCount + 8'd1;
      end
   end
`endif

endmodule
